line_buffer: RTL and testbench

LINE_BUFFER -- requirements
Module: line_buffer

---
 rtl/line_buffer_if.sv | 43 ++++
 rtl/line_buffer.sv | 191 +++++++++++++++++++
 tb/tb_line_buffer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/line_buffer_if.sv
// Bundle of the line buffer's control, memory-read and pixel-window signals.
// The slave modport is the line buffer itself; the master modport is the
// side that drives start/adv and answers memory reads.
interface line_buffer_if #(
   parameter int AW = 15
);
   logic          start;
   logic          adv;
   logic          mem_en;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_rdata;
   logic [31:0]   dataRa;
   logic [31:0]   dataRb;
   logic [31:0]   dataRc;
   logic          row_cached;
   logic          done;

   modport slave (
      input  start,
      input  adv,
      input  mem_rdata,
      output mem_en,
      output mem_addr,
      output dataRa,
      output dataRb,
      output dataRc,
      output row_cached,
      output done
   );

   modport master (
      output start,
      output adv,
      output mem_rdata,
      input  mem_en,
      input  mem_addr,
      input  dataRa,
      input  dataRb,
      input  dataRc,
      input  row_cached,
      input  done
   );
endinterface

// File: rtl/line_buffer.sv
// Three-row sliding window over a frame stored as 32-bit words (4 pixels each).
// For position p the block presents word p (dataRb), the word one row above
// (dataRa, p-RW) and the word one row below (dataRc, p+RW), reading the frame
// sequentially from memory exactly once.
//
// Data path: dataRc register -> 2*RW-word shift chain.  The chain tap at RW-1
// is dataRb and the last tap is dataRa.  The next dataRc comes from a one-word
// prefetch register, or straight from mem_rdata when the word lands in the
// same cycle it is needed.  A read is launched in the same cycle an advance is
// accepted so its word is back in time for an advance on the very next cycle;
// that keeps one position per cycle with a single word of look-ahead.
module line_buffer #(
   parameter int WIDTH  = 352,
   parameter int HEIGHT = 288
) (
   input  logic         clk,
   input  logic         rst,
   line_buffer_if.slave bus
);

   localparam int RW = WIDTH / 4;
   localparam int N  = (WIDTH * HEIGHT) / 4;
   localparam int AW = $clog2(N);
   localparam int DL = 2 * RW;

   localparam logic [AW-1:0] LAST_IDX   = AW'(N - 1);
   localparam logic [AW-1:0] PRIME_LAST = AW'(RW + 1);
   localparam logic [AW-1:0] ONE        = AW'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRIME = 3'd1,
      S_READY = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        r_state;
   logic [AW-1:0] r_addr;        // next read address, saturates at N-1
   logic [AW-1:0] r_pos;         // current window position p
   logic          r_rd_pend;     // a read was issued last cycle; mem_rdata is valid
   logic          r_pf_v;
   logic [31:0]   r_pf;
   logic          r_row_cached;
   logic          r_done;
   logic [31:0]   r_c;
   logic [31:0]   r_dl [DL];

   logic          w_run;
   logic          w_acc;
   logic          w_last_pos;
   logic          w_adv_shift;
   logic          w_mem_en;
   logic          w_clear;
   logic          w_dl_shift;
   logic [31:0]   w_c_in;

   // Decode advance acceptance, read launch and the word entering dataRc.
   always_comb begin
      w_run       = (r_state == S_READY) || (r_state == S_DRAIN);
      w_acc       = bus.adv && w_run;
      w_last_pos  = (r_pos == LAST_IDX);
      w_adv_shift = w_acc && !w_last_pos;
      w_mem_en    = (r_state == S_PRIME) || ((r_state == S_READY) && w_adv_shift);
      w_clear     = (r_state == S_IDLE);
      w_dl_shift  = ((r_state == S_PRIME) && r_rd_pend) || w_adv_shift;
      w_c_in      = 32'd0;
      if (r_state == S_PRIME) begin
         w_c_in = bus.mem_rdata;
      end else if (r_pf_v) begin
         w_c_in = r_pf;
      end else if (r_rd_pend) begin
         w_c_in = bus.mem_rdata;
      end else begin
         // Past the last row: zeros fill the row-below word.
         w_c_in = 32'd0;
      end
   end

   // Window shift chain: dataRc register followed by 2*RW delayed words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_c <= 32'd0;
         for (int i = 0; i < DL; i++) begin
            r_dl[i] <= 32'd0;
         end
      end else if (w_clear) begin
         r_c <= 32'd0;
         for (int i = 0; i < DL; i++) begin
            r_dl[i] <= 32'd0;
         end
      end else if (w_dl_shift) begin
         r_c     <= w_c_in;
         r_dl[0] <= r_c;
         for (int i = 1; i < DL; i++) begin
            r_dl[i] <= r_dl[i-1];
         end
      end
   end

   // Frame sequencing: state, counters, prefetch and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_pos        <= '0;
         r_rd_pend    <= 1'b0;
         r_pf_v       <= 1'b0;
         r_pf         <= 32'd0;
         r_row_cached <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_rd_pend <= w_mem_en;
         case (r_state)
            S_IDLE: begin
               r_addr       <= '0;
               r_pos        <= '0;
               r_pf_v       <= 1'b0;
               r_pf         <= 32'd0;
               r_row_cached <= 1'b0;
               r_done       <= 1'b0;
               if (bus.start) begin
                  r_state <= S_PRIME;
               end
            end

            S_PRIME: begin
               // Fill rows 0 and 1 up to word RW, plus one look-ahead read.
               if (r_addr == LAST_IDX) begin
                  r_state      <= S_DRAIN;
                  r_row_cached <= 1'b1;
               end else if (r_addr == PRIME_LAST) begin
                  r_state      <= S_READY;
                  r_addr       <= r_addr + ONE;
                  r_row_cached <= 1'b1;
               end else begin
                  r_addr <= r_addr + ONE;
               end
            end

            S_READY, S_DRAIN: begin
               if (w_acc && w_last_pos) begin
                  // Advancing off the final position ends the frame; window is frozen.
                  r_state      <= S_DONE;
                  r_row_cached <= 1'b0;
                  r_done       <= 1'b1;
               end else if (w_acc) begin
                  r_pos <= r_pos + ONE;
                  if (r_state == S_READY) begin
                     if (r_addr == LAST_IDX) begin
                        r_state <= S_DRAIN;
                     end else begin
                        r_addr <= r_addr + ONE;
                     end
                  end
               end
               // The look-ahead word is either consumed by this advance or parked.
               if (w_adv_shift) begin
                  r_pf_v <= 1'b0;
               end else if (r_rd_pend) begin
                  r_pf   <= bus.mem_rdata;
                  r_pf_v <= 1'b1;
               end
            end

            S_DONE: begin
               if (!bus.start) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b0;
               end
            end

            default: begin
               r_state      <= S_IDLE;
               r_row_cached <= 1'b0;
               r_done       <= 1'b0;
               r_pf_v       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_en     = w_mem_en;
   assign bus.mem_addr   = r_addr;
   assign bus.dataRc     = r_c;
   assign bus.dataRb     = r_dl[RW-1];
   assign bus.dataRa     = r_dl[DL-1];
   assign bus.row_cached = r_row_cached;
   assign bus.done       = r_done;

endmodule

// File: tb/tb_line_buffer.sv
// Randomized bench for line_buffer: memory returns data equal to address,
// window contents are predicted from the position arithmetic alone.
module tb_line_buffer;
   localparam int WIDTH  = 352;
   localparam int HEIGHT = 288;
   localparam int RW     = WIDTH / 4;
   localparam int N      = (WIDTH * HEIGHT) / 4;
   localparam int AW     = $clog2(N);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tb_clr = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;
   int rd_cnt = 0;
   int rd_bad = 0;

   line_buffer_if #(.AW(AW)) bus ();

   line_buffer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Memory model (data = address, one cycle later) and read-order log.
   always @(posedge clk) begin
      if (bus.mem_en) begin
         bus.mem_rdata <= 32'(bus.mem_addr);
      end
      if (tb_clr) begin
         rd_cnt <= 0;
         rd_bad <= 0;
      end else if (bus.mem_en) begin
         if (int'(bus.mem_addr) != rd_cnt) rd_bad <= rd_bad + 1;
         rd_cnt <= rd_cnt + 1;
      end
   end

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference window for position p of a frame whose words equal their index.
   function automatic longint ref_b(int p);
      return longint'(p);
   endfunction
   function automatic longint ref_c(int p);
      return (p + RW < N) ? longint'(p + RW) : 64'd0;
   endfunction
   function automatic longint ref_a(int p);
      return (p >= RW) ? longint'(p - RW) : 64'd0;
   endfunction
   function automatic longint ref_reads(int p);
      return (p + RW + 2 < N) ? longint'(p + RW + 2) : longint'(N);
   endfunction

   task automatic check_zero(input string tag);
      check_val({tag, "_Ra"}, bus.dataRa, 0);
      check_val({tag, "_Rb"}, bus.dataRb, 0);
      check_val({tag, "_Rc"}, bus.dataRc, 0);
      check_val({tag, "_row_cached"}, bus.row_cached, 0);
      check_val({tag, "_done"}, bus.done, 0);
      check_val({tag, "_mem_en"}, bus.mem_en, 0);
      check_val({tag, "_mem_addr"}, bus.mem_addr, 0);
   endtask

   task automatic prime_frame(input string tag);
      int cyc;
      tb_clr    = 1'b0;
      bus.start = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            check_val({tag, "_first_rd_en"}, bus.mem_en, 1);
            check_val({tag, "_first_rd_addr"}, bus.mem_addr, 0);
         end
      end while (!bus.row_cached && cyc < 200);
      check_val({tag, "_prime_cycles"}, cyc, RW + 3);
      check_val({tag, "_prime_reads"}, rd_cnt, RW + 2);
      check_val({tag, "_prime_order"}, rd_bad, 0);
      check_val({tag, "_p0_Rb"}, bus.dataRb, 0);
      check_val({tag, "_p0_Rc"}, bus.dataRc, RW);
      check_val({tag, "_p0_Ra"}, bus.dataRa, 0);
   endtask

   // Walk the frame with adv high pct% of cycles, stopping at stop_p or DONE.
   task automatic run_frame(input string tag, input int pct, input int stop_p);
      int  p;
      bit  done_exp;
      logic a;
      p = 0;
      done_exp = 1'b0;
      for (int cyc = 0; cyc < 4 * N; cyc++) begin
         check_val({tag, "_Rb"}, bus.dataRb, ref_b(p));
         check_val({tag, "_Rc"}, bus.dataRc, ref_c(p));
         check_val({tag, "_Ra"}, bus.dataRa, ref_a(p));
         check_val({tag, "_row_cached"}, bus.row_cached, done_exp ? 0 : 1);
         check_val({tag, "_done"}, bus.done, done_exp ? 1 : 0);
         check_val({tag, "_reads"}, rd_cnt, ref_reads(p));
         if (p == N - 1 && !done_exp) begin
            check_val({tag, "_tail_Rb"}, bus.dataRb, 25343);
            check_val({tag, "_tail_Ra"}, bus.dataRa, 25255);
            check_val({tag, "_tail_Rc"}, bus.dataRc, 0);
         end
         if (done_exp || p == stop_p) break;
         a = ($urandom_range(99) < pct) ? 1'b1 : 1'b0;
         bus.adv = a;
         @(negedge clk);
         if (a) begin
            if (p == N - 1) done_exp = 1'b1;
            else p++;
         end
      end
      bus.adv = 1'b0;
      check_val({tag, "_reached_end"}, (done_exp || p == stop_p) ? 1 : 0, 1);
   endtask

   task automatic finish_frame(input string tag);
      bus.adv = 1'b1;
      repeat (3) @(negedge clk);
      check_val({tag, "_done_hold"}, bus.done, 1);
      check_val({tag, "_done_rc"}, bus.row_cached, 0);
      check_val({tag, "_done_Rb"}, bus.dataRb, N - 1);
      check_val({tag, "_total_reads"}, rd_cnt, N);
      check_val({tag, "_read_order"}, rd_bad, 0);
      bus.adv   = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      check_val({tag, "_idle_done"}, bus.done, 0);
      check_val({tag, "_idle_rc"}, bus.row_cached, 0);
      @(negedge clk);
      check_zero({tag, "_idle"});
      check_val({tag, "_reads_after"}, rd_cnt, N);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.adv   = 1'b0;
      rst       = 1'b1;
      tb_clr    = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("in_reset");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_zero("idle_no_start");
      check_val("idle_reads", rd_cnt, 0);

      // Frame 1: random gaps in adv.
      prime_frame("f1");
      run_frame("f1", 75, -1);
      finish_frame("f1");

      // Frame 2: abandoned by reset at position 1000.
      tb_clr = 1'b1;
      @(negedge clk);
      prime_frame("f2");
      run_frame("f2", 100, 1000);
      #2;
      rst       = 1'b1;
      bus.start = 1'b0;
      tb_clr    = 1'b1;
      #1;
      check_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("midrst_idle");

      // Frame 3: restart after reset, adv held high throughout.
      prime_frame("f3");
      run_frame("f3", 100, -1);
      finish_frame("f3");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
